logic_unit_pipe: RTL
====================

# logic_unit_pipe

Parametrised, streaming successor to the single-shot logic operation unit. It accepts one operand pair plus opcode per cycle over a valid/ready handshake and computes one of 16 bitwise/shift/rotate operations. Results are queued in a small output FIFO with zero and illegal-opcode flags. It sits between the MIPS decode/issue stage and writeback, so back-pressure from writeback never forces recomputation.

## Interface
Parameters:
- WIDTH, 32, operand/result width; power of 2, ≥ 4.
- DEPTH, 2, result FIFO entries; power of 2, ≥ 2.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair and opcode are valid.
- in_ready  out  1  unit can accept this cycle.
- A  in  WIDTH  operand A, unsigned.
- B  in  WIDTH  operand B, unsigned; low log2(WIDTH) bits are the shift amount for ops 8–12.
- log_op  in  4  opcode.
- out_valid  out  1  FIFO head holds a result.
- out_ready  in  1  consumer takes head this cycle.
- C  out  WIDTH  result at FIFO head.
- zero  out  1  head result == 0.
- illegal  out  1  head result came from a reserved opcode.
- count  out  log2(DEPTH)+1  FIFO occupancy.

## Operation
- Opcodes: 0 NOT A; 1 NOT B; 2 AND; 3 OR; 4 XOR; 5 NAND; 6 NOR; 7 XNOR; 8 SLL A by sh; 9 SRL A by sh; 10 SRA A by sh (sign = A[WIDTH-1]); 11 ROL A by sh; 12 ROR A by sh; 13 PASS A; 14 PASS B; 15 reserved.
- sh = B[log2(WIDTH)-1:0]; upper bits of B are ignored for shifts and rotates (B=36, WIDTH=32 → sh=4).
- Reserved opcode: result 0, zero=1, illegal=1. The entry is still enqueued and consumes a slot. No other side effect.
- Accept (push) when in_valid && in_ready. The result is computed combinationally from A/B/log_op and written with its flags into the FIFO tail on that edge.
- Pop when out_valid && out_ready. The head advances on that edge.
- in_ready = reset_n && (count < DEPTH). A push is not accepted when full, even if a pop occurs the same cycle (no full-pass-through).
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, order preserved.
- out_valid = (count != 0). A pop cannot occur when empty, so push-while-empty only increments count.
- C, zero and illegal are forced to 0 whenever out_valid = 0.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. Strict FIFO order.
- Outputs are stable while out_valid=1 and out_ready=0.
- Inputs are ignored when in_valid=0 or in_ready=0. There is no sticky finish flag; each handshake is exactly one operation.

## Timing
- Reset (reset_n low, asynchronous): count=0, pointers=0, out_valid=0, C=0, zero=0, illegal=0, in_ready=0. FIFO storage contents are don't-care.
- First rising edge after reset_n rises: in_ready=1, combinationally from reset_n and count.
- Latency: operation accepted at edge k → out_valid=1 with its result after edge k (visible in cycle k+1), provided it is the only FIFO entry.
- Throughput: 1 operation/cycle while out_ready=1.
- Reset mid-operation: all pending results are discarded immediately, without waiting for a clock edge. An in-flight handshake on the same edge is dropped.
- in_ready and out_valid are functions of registered state only. There is no combinational path from in_valid to in_ready or from out_ready to out_valid.

## Test plan
All scenarios use WIDTH=32, DEPTH=2.
- Reset: hold reset_n=0 for 3 cycles with random inputs → in_ready=0, out_valid=0, C=0, count=0. Release → in_ready=1 at the next edge.
- AND: A=F0F0F0F0, B=FF00FF00, op=2, out_ready=1 → one cycle later out_valid=1, C=F000F000, zero=0, illegal=0. Then NOT A with A=FFFFFFFF → C=0, zero=1.
- Back-pressure: out_ready=0; push XOR(0000FFFF, FFFFFFFF), then OR(1,2), then attempt NOR(0,0) → after 2 accepts count=2, in_ready=0 and the third is not taken. Raise out_ready → C=FFFF0000, then 00000003 on consecutive cycles, then count=0. Re-presenting NOR is accepted → C=FFFFFFFF.
- Shifts/rotates: SRA A=80000000, B=00000024 → F8000000. ROL A=80000001, B=1 → 00000003. ROR A=00000001, B=1 → 80000000. SLL A=1, B=0x1F → 80000000. SRL A=80000000, B=0x1F → 00000001.
- Reserved opcode: op=15, A=B=FFFFFFFF → entry enqueued, C=0, zero=1, illegal=1. The next valid op clears illegal at head.
- Streaming and reset mid-flight: 20 back-to-back random ops with random out_ready → results match the reference model in order, with no drops or duplicates. Then fill the FIFO (count=2) and pulse reset_n low off-edge → out_valid=0 and count=0 before the next clock edge.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// Streaming bitwise/shift/rotate unit: one op per valid/ready handshake,
// results with zero/illegal flags queued in a small FIFO ahead of writeback.
module logic_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           A,
  input  logic [WIDTH-1:0]           B,
  input  logic [3:0]                 log_op,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           C,
  output logic                       zero,
  output logic                       illegal,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int SW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] c;
    logic             zero;
    logic             illegal;
  } entry_t;

  logic [SW-1:0]    sh;
  logic [SW:0]      inv_sh;
  logic [WIDTH-1:0] res;
  logic             res_ill;
  entry_t           new_entry;
  entry_t           head;
  entry_t           mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             push, pop;

  assign sh     = B[SW-1:0];
  // inv_sh == WIDTH when sh == 0, so the rotate's wrap term shifts out to zero
  assign inv_sh = (SW+1)'(WIDTH) - {1'b0, sh};

  always_comb begin
    res     = '0;
    res_ill = 1'b0;
    case (log_op)
      4'd0:  res = ~A;
      4'd1:  res = ~B;
      4'd2:  res = A & B;
      4'd3:  res = A | B;
      4'd4:  res = A ^ B;
      4'd5:  res = ~(A & B);
      4'd6:  res = ~(A | B);
      4'd7:  res = ~(A ^ B);
      4'd8:  res = A << sh;
      4'd9:  res = A >> sh;
      4'd10: res = $unsigned($signed(A) >>> sh);
      4'd11: res = (A << sh) | (A >> inv_sh);
      4'd12: res = (A >> sh) | (A << inv_sh);
      4'd13: res = A;
      4'd14: res = B;
      default: begin
        res     = '0;
        res_ill = 1'b1;
      end
    endcase
  end

  assign new_entry = '{c: res, zero: (res == '0), illegal: res_ill};

  assign in_ready  = reset_n && (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is read until count says an entry exists.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  assign head    = mem[rd_ptr];
  assign C       = out_valid ? head.c       : '0;
  assign zero    = out_valid ? head.zero    : 1'b0;
  assign illegal = out_valid ? head.illegal : 1'b0;
endmodule
